// File: rtl/sample_packer_pkg.sv
// Shared types and default sizing for the sample packer.
package sample_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int SAMPLE_WIDTH_DEF = 16;
  localparam int WORD_WIDTH_DEF   = 128;
  localparam int BURST_WORDS_DEF  = 8;

endpackage

// File: rtl/sample_packer.sv
// Packs audio samples into wide AXI-Stream words, grouped into tlast-terminated bursts.
// Optional macro SAMPLE_PACKER_FLUSH_EN adds a flush input that closes the current word/burst early.
module sample_packer
  import sample_packer_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int WORD_WIDTH   = WORD_WIDTH_DEF,
  parameter int BURST_WORDS  = BURST_WORDS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_sample,
  input  logic                    prog_full,
`ifdef SAMPLE_PACKER_FLUSH_EN
  input  logic                    flush,
`endif
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [WORD_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic [15:0]             burst_count
);

  localparam int LANES   = WORD_WIDTH / SAMPLE_WIDTH;
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BURST_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [BURST_W-1:0] LAST_WORD = BURST_W'(BURST_WORDS - 1);

  state_e                 state_q, state_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [BURST_W-1:0]     burst_idx_q, burst_idx_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic                   tlast_q, tlast_d;
  logic [15:0]            burst_count_q, burst_count_d;
  logic                   flush_req;
  logic                   accept;

`ifdef SAMPLE_PACKER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // The word register doubles as the output data; it is cleared after each handshake
  // so that a flushed word carries zeros in its unfilled lanes.
  assign s_ready       = (state_q == FILL);
  assign accept        = s_valid && s_ready;
  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = word_q;
  assign m_axis_tlast  = tlast_q;
  assign burst_count   = burst_count_q;

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    burst_idx_d   = burst_idx_q;
    word_d        = word_q;
    tlast_d       = tlast_q;
    burst_count_d = burst_count_q;
    unique case (state_q)
      IDLE: begin
        if (!prog_full) state_d = FILL;
      end
      FILL: begin
        if (accept) begin
          word_d[int'(lane_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = s_sample;
          lane_d = lane_q + 1'b1;
        end
        if (accept && (lane_q == LAST_LANE)) begin
          state_d = SEND;
          lane_d  = '0;
          tlast_d = (burst_idx_q == LAST_WORD) || flush_req;
        end else if (flush_req && (accept || (lane_q != '0) || (burst_idx_q != '0))) begin
          // Flush with nothing buffered in an empty burst has nothing to close.
          state_d = SEND;
          lane_d  = '0;
          tlast_d = 1'b1;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          word_d  = '0;
          tlast_d = 1'b0;
          if (tlast_q) begin
            burst_idx_d   = '0;
            burst_count_d = burst_count_q + 16'd1;
            state_d       = IDLE;
          end else begin
            burst_idx_d = burst_idx_q + 1'b1;
            state_d     = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      lane_q        <= '0;
      burst_idx_q   <= '0;
      word_q        <= '0;
      tlast_q       <= 1'b0;
      burst_count_q <= '0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      burst_idx_q   <= burst_idx_d;
      word_q        <= word_d;
      tlast_q       <= tlast_d;
      burst_count_q <= burst_count_d;
    end
  end

endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: vector table, directed corner sequences and a
// randomized run scored against a queue-based model of the packing rules.
module tb_sample_packer;
  import sample_packer_pkg::*;

  localparam int SW    = SAMPLE_WIDTH_DEF;
  localparam int WW    = WORD_WIDTH_DEF;
  localparam int BW    = BURST_WORDS_DEF;
  localparam int LANES = WW / SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_sample = '0;
  logic          prog_full = 1'b1;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [WW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic [15:0]   burst_count;
`ifdef SAMPLE_PACKER_FLUSH_EN
  logic          flush = 1'b0;
`endif

  always #5 clk = ~clk;

  sample_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_sample      (s_sample),
    .prog_full     (prog_full),
`ifdef SAMPLE_PACKER_FLUSH_EN
    .flush         (flush),
`endif
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .burst_count   (burst_count)
  );

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    logic        rst_n;
    logic        prog_full;
    logic        exp_ready;
    logic        exp_tvalid;
    logic        exp_tlast;
    logic [15:0] exp_bc;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Reference model: accepted samples gather in part_q; completed words wait in exp_q.
  logic [SW-1:0] part_q[$];
  word_t         exp_q[$];
  int            pos = 0;
  logic [15:0]   exp_bc = '0;
  logic          acc = 1'b0;
  logic          hold_v = 1'b0;
  logic [WW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;
  int            stalls = 0;
  int            words_seen = 0;
  int            lasts_seen = 0;
  int            last_idx = -1;
  logic [WW-1:0] first_word = '0;

  task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    pos    = 0;
    exp_bc = '0;
    hold_v = 1'b0;
  endtask

  task automatic queue_word(input logic force_last);
    word_t w;
    w.data = '0;
    foreach (part_q[i]) w.data[i*SW +: SW] = part_q[i];
    w.last = force_last || (pos == BW - 1);
    exp_q.push_back(w);
    pos = w.last ? 0 : pos + 1;
    part_q.delete();
  endtask

  // Looks at inputs and outputs as they stand before the coming rising edge.
  task automatic observe();
    word_t w;
    acc = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    chki("burst_count", int'(burst_count), int'(exp_bc));
    if (hold_v) begin
      chk1("hold_tvalid", m_axis_tvalid, 1'b1);
      chkw("hold_tdata", m_axis_tdata, hold_d);
      chk1("hold_tlast", m_axis_tlast, hold_l);
      chk1("hold_s_ready", s_ready, 1'b0);
    end
    hold_v = m_axis_tvalid && !m_axis_tready;
    hold_d = m_axis_tdata;
    hold_l = m_axis_tlast;
    if (hold_v) stalls++;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk1("tvalid_without_expected_word", m_axis_tvalid, 1'b0);
      end else begin
        w = exp_q.pop_front();
        chkw("tdata", m_axis_tdata, w.data);
        chk1("tlast", m_axis_tlast, w.last);
        if (w.last) exp_bc++;
      end
      if (m_axis_tlast) begin
        lasts_seen++;
        last_idx = words_seen;
      end
      if (words_seen == 0) first_word = m_axis_tdata;
      words_seen++;
    end
    acc = s_valid && s_ready;
    if (acc) part_q.push_back(s_sample);
`ifdef SAMPLE_PACKER_FLUSH_EN
    if (flush && s_ready && (part_q.size() > 0 || pos > 0)) queue_word(1'b1);
    else
`endif
    if (part_q.size() == LANES) queue_word(1'b0);
  endtask

  task automatic step();
    #1;
    observe();
    @(negedge clk);
  endtask

  task automatic feed(input int n, input logic [SW-1:0] base, input bit rnd, input int stall_word);
    int sent = 0;
    int budget = n * 20 + 200;
    while (sent < n && budget > 0) begin
      s_valid  = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      s_sample = rnd ? SW'($urandom) : base + SW'(sent);
      if (rnd) begin
        m_axis_tready = ($urandom_range(0, 9) < 6);
        prog_full     = ($urandom_range(0, 9) < 3);
      end else begin
        m_axis_tready = !(stall_word >= 0 && words_seen == stall_word && stalls < 5);
      end
      step();
      if (acc) sent++;
      budget--;
    end
    s_valid = 1'b0;
    if (sent < n) chki("feed_timeout", sent, n);
  endtask

  task automatic drain(input bit rnd);
    int budget = 500;
    s_valid = 1'b0;
    while ((exp_q.size() > 0 || m_axis_tvalid) && budget > 0) begin
      m_axis_tready = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
      step();
      budget--;
    end
    m_axis_tready = 1'b1;
    if (budget == 0) chki("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    vec_t          vecs[6];
    logic [WW-1:0] exp_w;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0};

    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      rst_n     = vecs[i].rst_n;
      prog_full = vecs[i].prog_full;
      s_valid   = 1'b0;
      #1;
      chk1($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].exp_ready);
      chk1($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].exp_tvalid);
      chk1($sformatf("vec%0d_tlast", i), m_axis_tlast, vecs[i].exp_tlast);
      chkw($sformatf("vec%0d_tdata", i), m_axis_tdata, '0);
      chki($sformatf("vec%0d_burst_count", i), int'(burst_count), int'(vecs[i].exp_bc));
      observe();
      @(negedge clk);
    end

    // prog_full held high keeps the packer idle until it drops.
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    prog_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk1("prog_full_hold_s_ready", s_ready, 1'b0);
    end
    prog_full = 1'b0;
    step();
    chk1("prog_full_release_s_ready", s_ready, 1'b1);

    // Ramp 0x0000..0x003F into one full burst.
    words_seen = 0; lasts_seen = 0; last_idx = -1;
    feed(64, 16'h0000, 1'b0, -1);
    drain(1'b0);
    chkw("ramp_word0", first_word, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chki("ramp_words", words_seen, 8);
    chki("ramp_tlast_count", lasts_seen, 1);
    chki("ramp_tlast_index", last_idx, 7);
    chki("ramp_burst_count", int'(burst_count), 1);

    // Back-pressure for five cycles on word 3.
    words_seen = 0; stalls = 0;
    feed(64, 16'h0040, 1'b0, 3);
    drain(1'b0);
    chki("stall_cycles", stalls, 5);
    chki("stall_words", words_seen, 8);
    chki("stall_burst_count", int'(burst_count), 2);

    // Reset after three samples of word 2, then a clean burst.
    words_seen = 0;
    feed(19, 16'h0200, 1'b0, -1);
    rst_n = 1'b0;
    step();
    chk1("rst_tvalid", m_axis_tvalid, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_tlast", m_axis_tlast, 1'b0);
    chkw("rst_tdata", m_axis_tdata, '0);
    chki("rst_burst_count", int'(burst_count), 0);
    step();
    rst_n = 1'b1;
    words_seen = 0; lasts_seen = 0; last_idx = -1;
    feed(64, 16'h0300, 1'b0, -1);
    drain(1'b0);
    exp_w = '0;
    for (int l = 0; l < LANES; l++) exp_w[l*SW +: SW] = SW'(16'h0300 + l);
    chkw("post_rst_word0", first_word, exp_w);
    chki("post_rst_words", words_seen, 8);
    chki("post_rst_tlast_index", last_idx, 7);
    chki("post_rst_burst_count", int'(burst_count), 1);

    // Random valid, ready and prog_full over three bursts.
    words_seen = 0;
    feed(192, '0, 1'b1, -1);
    drain(1'b1);
    prog_full = 1'b0;
    chki("rand_words", words_seen, 24);
    chki("rand_burst_count", int'(burst_count), 4);

`ifdef SAMPLE_PACKER_FLUSH_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4 && !s_ready; i++) step();
    chk1("flush_pre_s_ready", s_ready, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk1("flush_empty_ignored", m_axis_tvalid, 1'b0);
    words_seen = 0; lasts_seen = 0;
    feed(3, 16'h000A, 1'b0, -1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drain(1'b0);
    chkw("flush_word", first_word, 128'h0000_0000_0000_0000_0000_000C_000B_000A);
    chki("flush_words", words_seen, 1);
    chki("flush_tlast_count", lasts_seen, 1);
    chki("flush_burst_count", int'(burst_count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
